// File: rtl/vga_pkg.sv
// Shared VGA constants and small helpers for the character pixel path.
// Timing is 640x400 @ 70 Hz on a 25 MHz pixel clock; the box is one glyph cell.
package vga_pkg;

  typedef logic [2:0] rgb_t;
  typedef logic [2:0] col_t;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = 800;
  localparam int V_VISIBLE = 400;
  localparam int V_FRONT   = 12;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 35;
  localparam int V_TOTAL   = 449;

  localparam int BOX_X0 = 475;
  localparam int BOX_X1 = 482;
  localparam int BOX_Y0 = 241;
  localparam int BOX_Y1 = 256;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  localparam rgb_t FG_DEFAULT = 3'b111;
  localparam rgb_t BG_DEFAULT = 3'b000;

  function automatic col_t col_next(input col_t col, input col_t last);
    if (col == last) begin
      col_next = 3'd0;
    end else begin
      col_next = col + 3'd1;
    end
  endfunction

  // Outside the box is always black, whatever the background colour.
  function automatic rgb_t pixel_color(input logic de, input logic bit_on,
                                       input rgb_t fg, input rgb_t bg);
    if (!de) begin
      pixel_color = 3'b000;
    end else if (bit_on) begin
      pixel_color = fg;
    end else begin
      pixel_color = bg;
    end
  endfunction

endpackage

// File: rtl/char_pixel_gen_if.sv
// Character-code handshake from the keyboard decoder into the pixel generator.
interface char_pixel_gen_if;
  logic [7:0] char_code;
  logic       char_valid;
  logic       char_ready;

  modport master (output char_code, output char_valid, input  char_ready);
  modport slave  (input  char_code, input  char_valid, output char_ready);
endinterface

// File: rtl/glyph_rom.sv
// 16 hex-digit glyphs, 16 rows of 8 pixels each, MSB = leftmost pixel.
// Synchronous read: o_data is the row addressed on the previous clock.
module glyph_rom (
  input  logic       clk25,
  input  logic       reset,
  input  logic [7:0] i_addr,
  output logic [7:0] o_data
);

  function automatic logic [127:0] glyph_bits(input logic [3:0] code);
    case (code)
      4'h0: glyph_bits = 128'h0000_3C66_666E_7666_6666_663C_0000_0000;
      4'h1: glyph_bits = 128'h0000_3818_1818_1818_1818_187E_0000_0000;
      4'h2: glyph_bits = 128'h0000_3C66_0606_0C18_3060_607E_0000_0000;
      4'h3: glyph_bits = 128'h0000_3C66_0606_1C06_0606_663C_0000_0000;
      4'h4: glyph_bits = 128'h0000_0C1C_3C6C_CCFE_0C0C_0C0C_0000_0000;
      4'h5: glyph_bits = 128'h0000_7E60_6060_7C06_0606_663C_0000_0000;
      4'h6: glyph_bits = 128'h0000_3C66_6060_7C66_6666_663C_0000_0000;
      4'h7: glyph_bits = 128'h0000_7E66_060C_0C18_1818_1818_0000_0000;
      4'h8: glyph_bits = 128'h0000_3C66_6666_3C66_6666_663C_0000_0000;
      4'h9: glyph_bits = 128'h0000_3C66_6666_663E_0606_663C_0000_0000;
      4'hA: glyph_bits = 128'h0000_183C_6666_667E_6666_6666_0000_0000;
      4'hB: glyph_bits = 128'h0000_7C66_6666_7C66_6666_667C_0000_0000;
      4'hC: glyph_bits = 128'h0000_3C66_6060_6060_6060_663C_0000_0000;
      4'hD: glyph_bits = 128'h0000_786C_6666_6666_6666_6C78_0000_0000;
      4'hE: glyph_bits = 128'h0000_7E60_6060_7C60_6060_607E_0000_0000;
      4'hF: glyph_bits = 128'h0000_7E60_6060_7C60_6060_6060_0000_0000;
      default: glyph_bits = 128'h0;
    endcase
  endfunction

  logic [127:0] w_glyph;
  logic [127:0] w_shifted;
  logic [7:0]   r_data;

  // Row 0 sits in the top byte, so shift the wanted row up to [127:120].
  always_comb begin
    w_glyph   = glyph_bits(i_addr[7:4]);
    w_shifted = w_glyph << {i_addr[3:0], 3'b000};
  end

  // Registered read port.
  always_ff @(posedge clk25) begin
    if (reset) begin
      r_data <= 8'h00;
    end else begin
      r_data <= w_shifted[127:120];
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/char_pixel_gen.sv
// Renders one glyph cell: latches a keyboard code, swaps it in at frame start,
// and produces rgb with syncs through a 2-stage pipeline.
module char_pixel_gen #(
  parameter logic [2:0] FG_COLOR = vga_pkg::FG_DEFAULT,
  parameter logic [2:0] BG_COLOR = vga_pkg::BG_DEFAULT,
  parameter int         GLYPH_W  = vga_pkg::GLYPH_W
) (
  input  logic                   clk25,
  input  logic                   reset,
  input  logic                   hsync_in,
  input  logic                   vsync_in,
  input  logic                   display_area,
  input  logic [3:0]             line,
  char_pixel_gen_if.slave        char_if,
  output logic                   hsync_out,
  output logic                   vsync_out,
  output logic [2:0]             rgb
);
  import vga_pkg::*;

  localparam col_t COL_LAST = 3'(GLYPH_W - 1);

  logic       r_pend_empty;
  logic [7:0] r_pend_code;
  logic [7:0] r_cur_code;
  logic       r_vs_prev;
  col_t       r_col;

  logic       r1_de;
  col_t       r1_col;
  logic       r1_hs;
  logic       r1_vs;
  logic       r1_blank;

  rgb_t       r_rgb;
  logic       r_hs_out;
  logic       r_vs_out;

  logic       w_accept;
  logic       w_vs_rise;
  logic [7:0] w_rom_addr;
  logic [7:0] w_rom_row;
  logic       w_pix_bit;

  always_comb begin
    w_accept   = char_if.char_valid & r_pend_empty;
    w_vs_rise  = vsync_in & ~r_vs_prev;
    w_rom_addr = {r_cur_code[3:0], line};
    w_pix_bit  = w_rom_row[3'd7 - r1_col] & ~r1_blank;
  end

  // The ROM's read register is the stage-1 copy of the glyph address.
  glyph_rom u_glyph_rom (
    .clk25  (clk25),
    .reset  (reset),
    .i_addr (w_rom_addr),
    .o_data (w_rom_row)
  );

  // Pending/current code registers, vsync edge detect and column counter.
  always_ff @(posedge clk25) begin
    if (reset) begin
      r_pend_empty <= 1'b1;
      r_pend_code  <= 8'h00;
      r_cur_code   <= 8'h10;
      r_vs_prev    <= 1'b0;
      r_col        <= 3'd0;
    end else begin
      r_vs_prev <= vsync_in;
      if (w_vs_rise && !r_pend_empty) begin
        r_cur_code   <= r_pend_code;
        r_pend_empty <= 1'b1;
      end else if (w_accept) begin
        r_pend_code  <= char_if.char_code;
        r_pend_empty <= 1'b0;
      end else begin
        r_pend_empty <= r_pend_empty;
      end
      if (display_area) begin
        r_col <= col_next(r_col, COL_LAST);
      end else begin
        r_col <= 3'd0;
      end
    end
  end

  // Stage 1: delay the controls alongside the ROM read.
  always_ff @(posedge clk25) begin
    if (reset) begin
      r1_de    <= 1'b0;
      r1_col   <= 3'd0;
      r1_hs    <= 1'b1;
      r1_vs    <= 1'b0;
      r1_blank <= 1'b1;
    end else begin
      r1_de    <= display_area;
      r1_col   <= r_col;
      r1_hs    <= hsync_in;
      r1_vs    <= vsync_in;
      r1_blank <= (r_cur_code[7:4] != 4'h0);
    end
  end

  // Stage 2: colour select and aligned syncs.
  always_ff @(posedge clk25) begin
    if (reset) begin
      r_rgb    <= 3'b000;
      r_hs_out <= 1'b1;
      r_vs_out <= 1'b0;
    end else begin
      r_rgb    <= pixel_color(r1_de, w_pix_bit, FG_COLOR, BG_COLOR);
      r_hs_out <= r1_hs;
      r_vs_out <= r1_vs;
    end
  end

  assign char_if.char_ready = r_pend_empty;
  assign rgb       = r_rgb;
  assign hsync_out = r_hs_out;
  assign vsync_out = r_vs_out;

endmodule

// File: tb/tb_char_pixel_gen.sv
// Directed bench for char_pixel_gen: handshake, frame-synchronous commit,
// glyph rendering, sync alignment and mid-line reset.
module tb_char_pixel_gen;

  localparam logic [2:0] FG = 3'b111;
  localparam logic [2:0] BG = 3'b010;

  logic       clk25;
  logic       reset;
  logic       hsync_in;
  logic       vsync_in;
  logic       display_area;
  logic [3:0] line;
  logic       hsync_out;
  logic       vsync_out;
  logic [2:0] rgb;

  int n_checks;
  int n_pass;

  char_pixel_gen_if u_cif ();

  char_pixel_gen #(
    .FG_COLOR (FG),
    .BG_COLOR (BG),
    .GLYPH_W  (8)
  ) dut (
    .clk25        (clk25),
    .reset        (reset),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .display_area (display_area),
    .line         (line),
    .char_if      (u_cif),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .rgb          (rgb)
  );

  initial clk25 = 1'b0;
  always #20 clk25 = ~clk25;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk25);
    #1;
  endtask

  task automatic offer(input logic [7:0] code);
    u_cif.char_code  = code;
    u_cif.char_valid = 1'b1;
    step();
    u_cif.char_valid = 1'b0;
  endtask

  task automatic vs_pulse();
    vsync_in = 1'b1;
    step();
    vsync_in = 1'b0;
    step();
  endtask

  // Pixel p appears on rgb one loop pass after the pass that drove it.
  task automatic render_line(input string tag, input logic [3:0] ln, input logic [7:0] row);
    logic [2:0] exp;
    for (int i = 0; i < 10; i++) begin
      display_area = (i < 8);
      line = ln;
      step();
      if (i >= 1 && i <= 8) begin
        exp = row[8 - i] ? FG : BG;
      end else begin
        exp = 3'b000;
      end
      check_eq($sformatf("%s_l%0d_p%0d", tag, ln, i - 1), {29'd0, rgb}, {29'd0, exp});
    end
    display_area = 1'b0;
  endtask

  initial begin
    int first_hi;
    int n_hi;
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b0;
    display_area = 1'b0;
    line = 4'd0;
    u_cif.char_code  = 8'h00;
    u_cif.char_valid = 1'b0;
    step();
    step();
    check_eq("rst_ready", {31'd0, u_cif.char_ready}, 32'd1);
    check_eq("rst_rgb",   {29'd0, rgb},              32'd0);
    check_eq("rst_hs",    {31'd0, hsync_out},        32'd1);
    check_eq("rst_vs",    {31'd0, vsync_out},        32'd0);
    reset = 1'b0;
    step();

    // Accept 0x01; nothing shows until a vsync edge.
    offer(8'h01);
    check_eq("acc_ready_low", {31'd0, u_cif.char_ready}, 32'd0);
    step();
    check_eq("acc_rgb_idle", {29'd0, rgb}, 32'd0);
    render_line("pre_commit", 4'd3, 8'h00);
    vsync_in = 1'b1;
    step();
    check_eq("commit_ready", {31'd0, u_cif.char_ready}, 32'd1);
    vsync_in = 1'b0;
    step();
    render_line("glyph1", 4'd3, 8'h18);

    // hsync: 96-cycle low pulse, 2-cycle delay.
    for (int i = 0; i < 100; i++) begin
      hsync_in = (i < 96) ? 1'b0 : 1'b1;
      step();
      check_eq($sformatf("hs_%0d", i), {31'd0, hsync_out}, (i >= 1 && i <= 96) ? 32'd0 : 32'd1);
    end

    // vsync: 2-line pulse with empty pending register.
    first_hi = -1;
    n_hi = 0;
    for (int i = 0; i < 1604; i++) begin
      vsync_in = (i < 1600) ? 1'b1 : 1'b0;
      step();
      if (vsync_out) begin
        n_hi++;
        if (first_hi < 0) first_hi = i;
      end
    end
    check_eq("vs_first", first_hi, 32'd1);
    check_eq("vs_len",   n_hi,     32'd1600);
    render_line("no_commit", 4'd3, 8'h18);

    // Full pending register ignores a second offer.
    offer(8'h05);
    check_eq("p5_ready", {31'd0, u_cif.char_ready}, 32'd0);
    offer(8'h07);
    check_eq("p7_ready", {31'd0, u_cif.char_ready}, 32'd0);
    vsync_in = 1'b1;
    step();
    check_eq("p5_commit_ready", {31'd0, u_cif.char_ready}, 32'd1);
    vsync_in = 1'b0;
    step();
    render_line("glyph5", 4'd3, 8'h60);
    render_line("glyph5", 4'd2, 8'h7E);

    // Out-of-range code renders a blank box on every line.
    offer(8'h41);
    vs_pulse();
    for (int l = 0; l < 16; l++) begin
      render_line("blank41", 4'(l), 8'h00);
    end

    // Mid-line reset discards pending code and blanks the box.
    offer(8'h03);
    vs_pulse();
    offer(8'h02);
    display_area = 1'b1;
    line = 4'd3;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    check_eq("mid_rst_rgb",   {29'd0, rgb},              32'd0);
    check_eq("mid_rst_hs",    {31'd0, hsync_out},        32'd1);
    check_eq("mid_rst_vs",    {31'd0, vsync_out},        32'd0);
    check_eq("mid_rst_ready", {31'd0, u_cif.char_ready}, 32'd1);
    reset = 1'b0;
    display_area = 1'b0;
    step();
    render_line("post_rst", 4'd3, 8'h00);
    vs_pulse();
    render_line("post_rst_vs", 4'd3, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
